// File: rtl/noc_turn_arbiter.sv
// Per-output-port turn scheduler: round-robin arbitration among requesting inputs,
// producing the registered one-hot turn vector consumed by the route logic.
module noc_turn_arbiter #(
   parameter bit          NORTH    = 1'b1,
   parameter bit          SOUTH    = 1'b1,
   parameter bit          EAST     = 1'b1,
   parameter bit          WEST     = 1'b1,
   parameter bit          LOCAL    = 1'b1,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] req_i,
   input  logic       port_enable_i,
   input  logic       port_full_i,
   output logic [4:0] turn_o,
   output logic [2:0] grant_idx_o,
   output logic       err_o
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [4:0] IN_MASK   = {NORTH, SOUTH, EAST, WEST, LOCAL};
   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state_q, state_d;
   logic [4:0] turn_d;
   logic [4:0] last_q, last_d;
   logic [3:0] hold_q, hold_d;
   logic       err_d;
   logic [4:0] mreq;
   logic [4:0] winner;
   logic       rotate;

   // Search order runs from the bit below last downward, wrapping 0 -> 4,
   // so the previous winner is examined last.
   function automatic logic [4:0] rr_pick(input logic [4:0] req, input logic [4:0] last);
      logic [4:0] pick;
      int         li;
      int         c;
      pick = '0;
      li   = 0;
      for (int i = 0; i < 5; i++) begin
         if (last[i]) li = i;
      end
      for (int k = 1; k <= 5; k++) begin
         c = (li - k + 5) % 5;
         if (req[c[2:0]] && (pick == 5'b0)) pick[c[2:0]] = 1'b1;
      end
      return pick;
   endfunction

   assign mreq   = req_i & IN_MASK;
   assign winner = rr_pick(mreq, last_q);

   // In GRANT last_q always equals the holder, so one pick serves every rotation cause.
   // An enable while full is ignored, so it cannot end the grant.
   assign rotate = (port_enable_i && !port_full_i)
                || ((mreq & turn_o) == 5'b0)
                || (!port_full_i && (hold_q == HOLD_LAST));

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      turn_d  = turn_o;
      last_d  = last_q;
      hold_d  = hold_q;
      err_d   = err_o | (port_enable_i & ((state_q == IDLE) | port_full_i));
      unique case (state_q)
         IDLE: begin
            if (mreq != 5'b0) begin
               state_d = GRANT;
               turn_d  = winner;
               last_d  = winner;
               hold_d  = '0;
            end
         end
         GRANT: begin
            if (rotate) begin
               hold_d = '0;
               if (mreq != 5'b0) begin
                  turn_d = winner;
                  last_d = winner;
               end else begin
                  state_d = IDLE;
                  turn_d  = '0;
               end
            end else if (!port_full_i) begin
               hold_d = hold_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         turn_o  <= '0;
         last_q  <= 5'b00001;
         hold_q  <= '0;
         err_o   <= 1'b0;
      end else begin
         state_q <= state_d;
         turn_o  <= turn_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         err_o   <= err_d;
      end
   end

   always_comb begin
      unique case (turn_o)
         5'b10000: grant_idx_o = 3'd0;
         5'b01000: grant_idx_o = 3'd1;
         5'b00100: grant_idx_o = 3'd2;
         5'b00010: grant_idx_o = 3'd3;
         5'b00001: grant_idx_o = 3'd4;
         default:  grant_idx_o = 3'd7;
      endcase
   end

endmodule

// File: doc/noc_turn_arbiter.md
Name: noc_turn_arbiter

Overview:
- Per-output-port turn scheduler for the router. One instance per output port (N/S/E/W/L).
- Produces the registered one-hot turn vector the route logic consumes as X_turn. It decides which input may write this output port in a given cycle.
- Shares the port round-robin among requesting inputs. Rotates after each transfer, when the holder withdraws, or on a hold timeout.

Parameters:
- NORTH, 1, N input exists (0 = masked off permanently)
- SOUTH, 1, S input exists
- EAST, 1, E input exists
- WEST, 1, W input exists
- LOCAL, 1, L input exists
- MAX_HOLD, 4, max consecutive non-full cycles a grant is held without a transfer (range 1..15)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req_i  in  5  per-input request {N,S,E,W,L}, MSB=N; input holds a flit destined for this port
- port_enable_i  in  1  route logic wrote this output port this cycle (X_port_enable)
- port_full_i  in  1  this output port's buffer is full
- turn_o  out  5  registered one-hot turn: 10000=N, 01000=S, 00100=E, 00010=W, 00001=L, 00000=none
- grant_idx_o  out  3  encoded holder (000=N, 001=S, 010=E, 011=W, 100=L), 111 when none
- err_o  out  1  sticky protocol error flag

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: turn_o=00000, grant_idx_o=111, err_o=0, state=IDLE, last_grant=L (bit0), hold_cnt=0. Reset asserted mid-grant clears everything on the next edge, with no transfer completion implied.
- Masking: mreq = req_i & {NORTH,SOUTH,EAST,WEST,LOCAL}. Masked inputs are never granted.
- Round-robin order: N→S→E→W→L→N (bit4 down to bit0, wrapping). The search starts at the position after last_grant. The first set bit of mreq in that order wins, and last_grant itself is searched last. Next-grant logic is combinational; turn_o is registered.
- State IDLE (turn_o=0):
  - If mreq != 0, next edge: state=GRANT, turn_o=winner, last_grant=winner, hold_cnt=0.
  - Latency is 1 cycle from req to turn_o.
- State GRANT (turn_o = holder H), evaluated each cycle. The first matching rule applies:
  - port_enable_i=1: transfer done. Re-arbitrate using mreq with last_grant=H. H re-wins only if it is the sole requester. Go to IDLE if mreq=0. hold_cnt=0.
  - mreq[H]=0: holder withdrew. Re-arbitrate as above, or go to IDLE if mreq=0.
  - port_full_i=1: hold; hold_cnt frozen. No rotation while full.
  - hold_cnt==MAX_HOLD-1: timeout. Re-arbitrate, excluding H if any other mreq bit is set.
  - Otherwise: hold_cnt++.
- Throughput: back-to-back transfers are allowed. A new turn_o is valid the cycle after port_enable_i, so a single requester gets at most 1 flit per 2 cycles only if it drops req between flits. With steady req it keeps turn and may transfer every cycle.
- Invariants:
  - turn_o is always 0 or one-hot, with no bit set for a masked input.
  - grant_idx_o is consistent with turn_o in the same cycle.
- err_o sets (sticky until rst) on:
  - port_enable_i=1 while state=IDLE
  - port_enable_i=1 while port_full_i=1
  - The enable is otherwise ignored in both cases.
- hold_cnt is 4 bits. MAX_HOLD=1 means re-arbitrate after every non-full idle cycle.

Test Plan:
1. Reset then req_i=10000 → cycle+1 turn_o=10000, grant_idx_o=000. port_enable_i pulse with req still 10000 → turn_o stays 10000.
2. req_i=11111 held, port_enable_i=1 every GRANT cycle → turn_o sequence 10000, 01000, 00100, 00010, 00001, 10000 (one step per cycle).
3. Param NORTH=0, req_i=10010 → turn_o=00010 only; N never granted over 20 cycles.
4. MAX_HOLD=4, req_i=01001, granted S, no enable, port_full_i=0 → after 4 GRANT cycles turn_o=00001. Repeat with port_full_i=1 → turn_o stays 01000 indefinitely.
5. Granted E (00100), req_i drops to 00000 → next cycle turn_o=00000, grant_idx_o=111. A subsequent req_i=00100 re-grants E 1 cycle later.
6. port_enable_i=1 in IDLE → err_o=1 and stays 1 until rst. rst asserted mid-GRANT → next cycle turn_o=0, err_o=0, and the first grant after reset with req_i=11111 is N.
